router_pkt_fifo: RTL and testbench

Parametrised, packet-aware output FIFO for the router's destination channels, the successor to the fixed 16×8 channel FIFO. Each entry stores a data word plus a start-of-packet (SOP) tag. It tracks the remaining bytes of the packet currently being drained, and exports occupancy, almost-full and last-byte indications to the read-side synchroniser and the router FSM.

---
 rtl/router_pkg.sv | 11 +
 rtl/router_fifo_mem.sv | 21 ++
 rtl/router_pkt_fifo.sv | 102 ++++++++++
 tb/tb_router_pkt_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and entry type for the router packet FIFO
package router_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int HDR_LEN_LSB = 2;

  typedef struct packed {
    logic                  sop;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - DEPTH x (DATA_W+1) storage, synchronous write, asynchronous read
module router_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W:0]          rd_data
);
  logic [DATA_W:0] mem [DEPTH];

  // Contents are never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware router output FIFO with SOP tags and last-byte tracking
// Define ROUTER_FIFO_ERR_EN to build the sticky overflow/underflow flag on err.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   soft_rst,
  input  logic                   we,
  input  logic                   lfd_state,
  input  logic [DATA_W-1:0]      din,
  input  logic                   re,
  output logic [DATA_W-1:0]      dout,
  output logic                   sop_out,
  output logic                   pkt_last,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int REM_W  = DATA_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] AFULL_V = PTR_W'(AFULL_TH);
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

  logic [PTR_W-1:0]  wr_pt, rd_pt;
  logic              lfd_q;
  logic [REM_W-1:0]  rem;
  logic              wr_en, rd_en;
  logic [DATA_W:0]   rd_entry;
  logic              rd_sop;
  logic [DATA_W-1:0] rd_data;

  assign empty       = (wr_pt == rd_pt);
  assign full        = (wr_pt[ADDR_W] != rd_pt[ADDR_W]) &&
                       (wr_pt[ADDR_W-1:0] == rd_pt[ADDR_W-1:0]);
  assign count       = wr_pt - rd_pt;
  assign almost_full = (count >= AFULL_V);
  assign wr_en       = we && !full;
  assign rd_en       = re && !empty;
  assign {rd_sop, rd_data} = rd_entry;

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_pt[ADDR_W-1:0]),
    .wr_data ({lfd_q, din}),
    .rd_addr (rd_pt[ADDR_W-1:0]),
    .rd_data (rd_entry)
  );

  // The header length counts payload bytes; +1 covers the trailing parity byte.
  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      wr_pt    <= '0;
      rd_pt    <= '0;
      lfd_q    <= 1'b0;
      rem      <= '0;
      dout     <= '0;
      sop_out  <= 1'b0;
      pkt_last <= 1'b0;
    end else begin
      lfd_q <= lfd_state;
      if (wr_en) wr_pt <= wr_pt + PTR_ONE;
      if (rd_en) begin
        rd_pt    <= rd_pt + PTR_ONE;
        dout     <= rd_data;
        sop_out  <= rd_sop;
        pkt_last <= !rd_sop && (rem == REM_ONE);
        if (rd_sop)
          rem <= {1'b0, rd_data[DATA_W-1:HDR_LEN_LSB]} + REM_ONE;
        else if (rem != '0)
          rem <= rem - REM_ONE;
      end
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      err_q <= 1'b0;
    else if (!soft_rst && ((we && full) || (re && empty)))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - self-checking bench for router_pkt_fifo (queue reference model)
module tb_router_pkt_fifo;
  import router_pkg::*;

  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 14;
`ifdef ROUTER_FIFO_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, soft_rst, we, lfd_state, re;
  logic [7:0] din, dout;
  logic       sop_out, pkt_last, full, empty, almost_full, err;
  logic [4:0] count;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rstn(rstn), .soft_rst(soft_rst), .we(we), .lfd_state(lfd_state),
    .din(din), .re(re), .dout(dout), .sop_out(sop_out), .pkt_last(pkt_last),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  fifo_entry_t mq[$];
  bit          m_lfd, m_sop, m_last, m_err;
  int          m_rem;
  logic [7:0]  m_dout;

  typedef struct {
    bit         sr, w, l, r;
    logic [7:0] d;
    logic [7:0] e_dout;
    bit         e_sop, e_last;
    int         e_count;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; soft_rst = 1'b0; we = 1'b0; lfd_state = 1'b0; re = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    mq.delete();
    m_lfd = 0; m_sop = 0; m_last = 0; m_err = 0; m_rem = 0; m_dout = '0;
    chk("rst_dout", dout, 0);
    chk("rst_sop", sop_out, 0);
    chk("rst_last", pkt_last, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
  endtask

  // One clock: drive inputs, advance the queue model, then compare after the edge.
  task automatic cycle(input bit sr, input bit w, input bit l, input logic [7:0] d, input bit r);
    fifo_entry_t e;
    bit m_full, m_empty;
    soft_rst = sr; we = w; lfd_state = l; din = d; re = r;
    if (sr) begin
      mq.delete();
      m_rem = 0; m_dout = '0; m_sop = 0; m_last = 0; m_lfd = 0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      if (ERR_ON && ((w && m_full) || (r && m_empty))) m_err = 1;
      if (r && !m_empty) begin
        e = mq.pop_front();
        m_dout = e.data;
        m_sop  = e.sop;
        m_last = !e.sop && (m_rem == 1);
        if (e.sop) m_rem = int'(e.data) / 4 + 1;
        else if (m_rem > 0) m_rem--;
      end
      if (w && !m_full) begin
        e.sop = m_lfd;
        e.data = d;
        mq.push_back(e);
      end
      m_lfd = l;
    end
    @(posedge clk);
    #1;
    soft_rst = 1'b0; we = 1'b0; lfd_state = 1'b0; re = 1'b0;
    chk("m_dout", dout, m_dout);
    chk("m_sop", sop_out, m_sop);
    chk("m_last", pkt_last, m_last);
    chk("m_count", count, mq.size());
    chk("m_empty", empty, mq.size() == 0);
    chk("m_full", full, mq.size() == DEPTH);
    chk("m_afull", almost_full, mq.size() >= AFULL_TH);
    chk("m_err", err, m_err);
  endtask

  logic [7:0] fill_d[16];
  logic       err_before;

  initial begin
    // sr w l r  d      dout   sop last count
    tbl[0]  = '{0,0,1,0, 8'h00, 8'h00, 0,0, 0};
    tbl[1]  = '{0,1,0,0, 8'h0C, 8'h00, 0,0, 1};
    tbl[2]  = '{0,1,0,0, 8'hA1, 8'h00, 0,0, 2};
    tbl[3]  = '{0,1,0,0, 8'hA2, 8'h00, 0,0, 3};
    tbl[4]  = '{0,1,0,0, 8'hA3, 8'h00, 0,0, 4};
    tbl[5]  = '{0,1,0,0, 8'h5A, 8'h00, 0,0, 5};
    tbl[6]  = '{0,0,0,1, 8'h00, 8'h0C, 1,0, 4};
    tbl[7]  = '{0,0,0,1, 8'h00, 8'hA1, 0,0, 3};
    tbl[8]  = '{0,0,0,1, 8'h00, 8'hA2, 0,0, 2};
    tbl[9]  = '{0,0,0,1, 8'h00, 8'hA3, 0,0, 1};
    tbl[10] = '{0,0,0,1, 8'h00, 8'h5A, 0,1, 0};
    tbl[11] = '{0,0,1,0, 8'h00, 8'h5A, 0,1, 0};
    tbl[12] = '{0,1,0,0, 8'h00, 8'h5A, 0,1, 1};
    tbl[13] = '{0,1,0,0, 8'h77, 8'h5A, 0,1, 2};
    tbl[14] = '{0,0,0,1, 8'h00, 8'h00, 1,0, 1};
    tbl[15] = '{0,0,0,1, 8'h00, 8'h77, 0,1, 0};
    tbl[16] = '{0,0,0,0, 8'h00, 8'h77, 0,1, 0};

    do_reset();

    // Basic packet and zero-length header
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].sr, tbl[i].w, tbl[i].l, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      chk($sformatf("tbl%0d_sop", i), sop_out, tbl[i].e_sop);
      chk($sformatf("tbl%0d_last", i), pkt_last, tbl[i].e_last);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
    end
    chk("tbl_empty_end", empty, 1);

    // Fill, overflow attempt, then re+we while full
    cycle(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      fill_d[i] = 8'($urandom);
      cycle(0, 1, 0, fill_d[i], 0);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    cycle(0, 1, 0, 8'hEE, 0);
    chk("ovf_count", count, 16);
    chk("ovf_err", err, ERR_ON);
    cycle(0, 1, 0, 8'hDD, 1);
    chk("full_rw_count", count, 15);
    chk("full_rw_dout", dout, fill_d[0]);
    for (int i = 1; i < 16; i++) begin
      cycle(0, 0, 0, 8'h00, 1);
      chk($sformatf("drain%0d", i), dout, fill_d[i]);
    end
    chk("drain_empty", empty, 1);
    cycle(0, 1, 0, 8'h3C, 1);
    chk("empty_rw_count", count, 1);
    chk("empty_rw_dout", dout, fill_d[15]);
    cycle(0, 0, 0, 8'h00, 1);
    chk("empty_rw_read", dout, 8'h3C);

    // Wrap-around across two address wraps
    cycle(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 0, 8'(i), 0);
      cycle(0, 0, 0, 8'h00, 1);
      chk($sformatf("wrap%0d", i), dout, 8'(i));
    end

    // soft_rst mid-packet with 7 entries held
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h00, 0);
    cycle(0, 1, 0, 8'h20, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 0, 8'(i), 0);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);
    chk("sr_pre_count", count, 7);
    chk("sr_pre_dout", dout, 8'h01);
    chk("sr_pre_rem", 32'(dut.rem), 8);
    err_before = err;
    cycle(1, 1, 0, 8'h55, 1);
    chk("sr_empty", empty, 1);
    chk("sr_count", count, 0);
    chk("sr_dout", dout, 0);
    chk("sr_rem", 32'(dut.rem), 0);
    chk("sr_err_kept", err, err_before);

    // almost_full threshold
    for (int i = 0; i < 13; i++) cycle(0, 1, 0, 8'(i + 8'h40), 0);
    chk("af13", almost_full, 0);
    cycle(0, 1, 0, 8'h4D, 0);
    chk("af14", almost_full, 1);
    chk("af14_count", count, 14);
    cycle(0, 0, 0, 8'h00, 1);
    chk("af_back13", almost_full, 0);
    chk("af_back_count", count, 13);

    // Randomized traffic against the queue model
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 60,
            $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 99) < 55);

    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
